// File: rtl/mux_2x1_core.sv
// Purpose: combinational 2:1 selector, sel=0 picks a, sel=1 picks b.
// Latency: zero, purely combinational.
// Backpressure: none, output follows inputs continuously.
module mux_2x1_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] f
);

    assign f = sel ? b : a;

endmodule

// File: rtl/mux_2x1.sv
// Purpose: 2:1 data selector with combinational and registered outputs plus a sel-toggle counter.
// Latency: f is combinational; f_q/out_valid follow one clock after an in_valid cycle.
// Backpressure: none, every cycle's input is accepted.
module mux_2x1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sel_toggles,
    output logic             sel_q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mux_2x1_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (a),
        .b  (b),
        .sel(sel),
        .f  (f)
    );

    // f_q holds its last captured value across invalid cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f_q <= f;
            end
        end
    end

    // sel_q resets to 0, so a high sel on the first edge after reset counts as a toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= 1'b0;
            sel_toggles <= '0;
        end else begin
            sel_q <= sel;
            if ((sel != sel_q) && (sel_toggles != CNT_MAX)) begin
                sel_toggles <= sel_toggles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: truth-table sweep, latency, async reset, saturation, random regression.
module tb_mux_2x1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // d1: WIDTH=1, CNT_W=2
    logic       d1_a = 0, d1_b = 0, d1_sel = 0, d1_iv = 0;
    logic       d1_f, d1_fq, d1_ov, d1_sq;
    logic [1:0] d1_cnt;
    // d8: WIDTH=8, CNT_W=8
    logic [7:0] d8_a = 0, d8_b = 0, d8_f, d8_fq, d8_cnt;
    logic       d8_sel = 0, d8_iv = 0, d8_ov, d8_sq;
    // d16: WIDTH=16, CNT_W=8
    logic [15:0] d16_a = 0, d16_b = 0, d16_f, d16_fq;
    logic [7:0]  d16_cnt;
    logic        d16_sel = 0, d16_iv = 0, d16_ov, d16_sq;

    mux_2x1 #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .a(d1_a), .b(d1_b), .sel(d1_sel), .in_valid(d1_iv),
        .f(d1_f), .f_q(d1_fq), .out_valid(d1_ov), .sel_toggles(d1_cnt), .sel_q(d1_sq));

    mux_2x1 #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .a(d8_a), .b(d8_b), .sel(d8_sel), .in_valid(d8_iv),
        .f(d8_f), .f_q(d8_fq), .out_valid(d8_ov), .sel_toggles(d8_cnt), .sel_q(d8_sq));

    mux_2x1 #(.WIDTH(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .a(d16_a), .b(d16_b), .sel(d16_sel), .in_valid(d16_iv),
        .f(d16_f), .f_q(d16_fq), .out_valid(d16_ov), .sel_toggles(d16_cnt), .sel_q(d16_sq));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a;
        logic b;
        logic sel;
        logic f;
    } tt_vec_t;

    tt_vec_t tt [8];

    // reference model state for the random regression on dut16
    logic [15:0] m_fq;
    logic        m_ov;
    int          m_toggles;
    logic        m_prev_sel;

    initial begin
        tt[0] = '{0, 0, 0, 0};
        tt[1] = '{0, 0, 1, 0};
        tt[2] = '{0, 1, 0, 0};
        tt[3] = '{0, 1, 1, 1};
        tt[4] = '{1, 0, 0, 1};
        tt[5] = '{1, 0, 1, 0};
        tt[6] = '{1, 1, 0, 1};
        tt[7] = '{1, 1, 1, 1};

        // reset values appear before any clock edge
        #3;
        chk("rst_fq8", d8_fq, 0);
        chk("rst_ov8", d8_ov, 0);
        chk("rst_cnt8", d8_cnt, 0);
        chk("rst_selq8", d8_sq, 0);
        chk("rst_cnt1", d1_cnt, 0);
        chk("rst_ov16", d16_ov, 0);

        // exhaustive combinational sweep, applied during reset to show f ignores it
        for (int i = 0; i < 8; i++) begin
            d1_a = tt[i].a; d1_b = tt[i].b; d1_sel = tt[i].sel;
            #1;
            chk($sformatf("tt_f[%0d]", i), d1_f, tt[i].f);
        end

        // inputs presented at the first edge after reset release
        d1_sel = 1; d16_sel = 1; d16_iv = 0;
        d8_sel = 1; d8_iv = 0; d8_a = 8'h5A; d8_b = 8'hA5;
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            int sat_exp;
            tick();
            sat_exp = (i + 1 > 3) ? 3 : i + 1;
            chk($sformatf("sat_cnt1[%0d]", i), d1_cnt, sat_exp);
            chk($sformatf("hold_cnt16[%0d]", i), d16_cnt, 1);
            chk($sformatf("hold_selq16[%0d]", i), d16_sq, 1);
            d1_sel = ~d1_sel;
            case (i)
                0: begin
                    chk("d8_cnt_a", d8_cnt, 1);
                    d8_sel = 0;
                end
                1: begin
                    chk("d8_cnt_b", d8_cnt, 2);
                    d8_sel = 1; d8_iv = 1;
                end
                2: begin
                    chk("lat_fq", d8_fq, 8'hA5);
                    chk("lat_ov", d8_ov, 1);
                    chk("d8_cnt_c", d8_cnt, 3);
                    d8_iv = 0; d8_a = 8'h11; d8_b = 8'h22;
                end
                3: begin
                    chk("idle_ov", d8_ov, 0);
                    chk("idle_fq", d8_fq, 8'hA5);
                    d8_iv = 1; d8_a = 8'h5A; d8_b = 8'hA5;
                end
                default: begin
                    chk($sformatf("pre_rst_fq[%0d]", i), d8_fq, 8'hA5);
                    chk($sformatf("pre_rst_ov[%0d]", i), d8_ov, 1);
                    chk($sformatf("pre_rst_cnt[%0d]", i), d8_cnt, 3);
                end
            endcase
        end

        // asynchronous reset pulse between clock edges
        #2;
        rst = 1;
        #1;
        chk("arst_fq", d8_fq, 0);
        chk("arst_ov", d8_ov, 0);
        chk("arst_cnt", d8_cnt, 0);
        chk("arst_selq", d8_sq, 0);
        d8_a = 8'h33; d8_sel = 0;
        #1;
        chk("arst_f_follow", d8_f, 8'h33);
        d8_sel = 1;
        #1;
        chk("arst_f_follow_b", d8_f, 8'hA5);

        // random regression on dut16 from a fresh reset
        d16_iv = 0; d16_sel = 0;
        @(negedge clk);
        rst = 0;
        m_fq = 0; m_ov = 0; m_toggles = 0; m_prev_sel = 0;
        for (int c = 0; c < 1000; c++) begin
            d16_a   = 16'($urandom);
            d16_b   = 16'($urandom);
            d16_sel = 1'($urandom_range(0, 1));
            d16_iv  = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("rnd_f[%0d]", c), d16_f, d16_sel ? d16_b : d16_a);
            if (d16_iv) m_fq = d16_sel ? d16_b : d16_a;
            m_ov = d16_iv;
            if (d16_sel != m_prev_sel) m_toggles++;
            m_prev_sel = d16_sel;
            tick();
            chk($sformatf("rnd_fq[%0d]", c), d16_fq, m_fq);
            chk($sformatf("rnd_ov[%0d]", c), d16_ov, m_ov);
            chk($sformatf("rnd_cnt[%0d]", c), d16_cnt, (m_toggles > 255) ? 255 : m_toggles);
            chk($sformatf("rnd_selq[%0d]", c), d16_sq, m_prev_sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
